// File: rtl/multi_channel_decimator.sv
// multi_channel_decimator
// Block decimator for NUM_CH channels that share one sample strobe. Each block
// of DF = 2^k_eff samples is reduced per channel to a single output sample by
// averaging, keeping the first sample, or (optionally) peak/valley detection.
// Configuration macro: PEAK_DETECT_EN -- when defined, modes 10/11 select
// max/min with unsigned comparators; when undefined the comparators are not
// built and modes 10/11 behave like average (00).
module multi_channel_decimator #(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 12,
  parameter int NUM_CH    = 2,
  localparam int BIT_DIFF = BITS_ACUM - BITS_ADC,
  localparam int KW       = $clog2(BIT_DIFF) + 1,
  localparam int CW       = BIT_DIFF + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KW-1:0]              k,
  input  logic [1:0]                 mode,
  input  logic [NUM_CH*BITS_ADC-1:0] samples_in,
  input  logic                       rdy_in,
  output logic [NUM_CH*BITS_ADC-1:0] samples_out,
  output logic                       rdy_out,
  output logic                       cfg_err
);

  localparam logic [1:0] MODE_AVG = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
`ifdef PEAK_DETECT_EN
  localparam logic [1:0] MODE_MAX = 2'b10;
  localparam logic [1:0] MODE_MIN = 2'b11;
`endif

  // Shared block state: all channels advance in lockstep on one counter.
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [KW-1:0]              k_eff_q;
  logic [1:0]                 mode_q;
  logic                       cfg_err_q;
  logic                       rdy_out_q;
  logic [NUM_CH*BITS_ADC-1:0] samples_out_q;

  logic                       start;
  logic                       done;
  logic                       k_over;
  logic [KW-1:0]              k_new;
  logic [KW-1:0]              k_use;
  logic [1:0]                 mode_use;
  logic [CW-1:0]              df_m1;
  logic                       is_avg;
`ifdef PEAK_DETECT_EN
  logic                       is_max;
  logic                       is_min;
`endif
  logic [NUM_CH*BITS_ADC-1:0] result_w;

  // Block control: clamp k, detect block start/completion, next counter value.
  // At a block start the live k/mode inputs govern the block (including DF=1
  // blocks that complete on the same sample), otherwise the shadow copies do.
  always_comb begin
    start    = rdy_in && (cnt_q == '0);
    k_over   = (k > KW'(BIT_DIFF));
    k_new    = k_over ? KW'(BIT_DIFF) : k;
    df_m1    = (CW'(1) << k_new) - CW'(1);
    k_use    = start ? k_new : k_eff_q;
    mode_use = start ? mode : mode_q;
    done     = 1'b0;
    cnt_d    = cnt_q;
    if (rdy_in) begin
      if (start) begin
        cnt_d = df_m1;
        done  = (df_m1 == '0);
      end else begin
        cnt_d = cnt_q - CW'(1);
        done  = (cnt_q == CW'(1));
      end
    end
  end

  // Mode decode; without peak detection every mode other than decimate averages.
  always_comb begin
`ifdef PEAK_DETECT_EN
    is_avg = (mode_use == MODE_AVG);
    is_max = (mode_use == MODE_MAX);
    is_min = (mode_use == MODE_MIN);
`else
    is_avg = (mode_use != MODE_DEC);
`endif
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BITS_ADC-1:0]  smp;
      logic [BITS_ACUM-1:0] smp_ext;
      logic [BITS_ACUM-1:0] acc_q, acc_d;
      logic [BITS_ACUM-1:0] acc_shr;

      assign smp     = samples_in[gi*BITS_ADC +: BITS_ADC];
      assign smp_ext = BITS_ACUM'(smp);

      // Per-channel accumulator update: load on block start, else fold by mode.
      // The average sum cannot overflow because k_eff never exceeds BIT_DIFF.
      always_comb begin
        acc_d = acc_q;
        if (rdy_in) begin
          if (start) begin
            acc_d = smp_ext;
          end else if (is_avg) begin
            acc_d = acc_q + smp_ext;
`ifdef PEAK_DETECT_EN
          end else if (is_max) begin
            acc_d = (smp_ext > acc_q) ? smp_ext : acc_q;
          end else if (is_min) begin
            acc_d = (smp_ext < acc_q) ? smp_ext : acc_q;
`endif
          end
        end
      end

      assign acc_shr = acc_d >> k_use;
      assign result_w[gi*BITS_ADC +: BITS_ADC] =
        is_avg ? acc_shr[BITS_ADC-1:0] : acc_d[BITS_ADC-1:0];

      // Accumulator register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  endgenerate

  // Shared state: counter, shadow config, sticky error, registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      k_eff_q       <= '0;
      mode_q        <= '0;
      cfg_err_q     <= 1'b0;
      rdy_out_q     <= 1'b0;
      samples_out_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rdy_out_q <= done;
      if (start) begin
        k_eff_q <= k_new;
        mode_q  <= mode;
        if (k_over) begin
          cfg_err_q <= 1'b1;
        end
      end
      if (done) begin
        samples_out_q <= result_w;
      end
    end
  end

  assign samples_out = samples_out_q;
  assign rdy_out     = rdy_out_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_multi_channel_decimator.sv
// Testbench for multi_channel_decimator (default parameters: 8-bit samples,
// 12-bit accumulators, 2 channels). The reference model collects each block's
// samples in queues and reduces them arithmetically when the block is full.
module tb_multi_channel_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  k;
  logic [1:0]  mode;
  logic [15:0] samples_in;
  logic        rdy_in;
  logic [15:0] samples_out;
  logic        rdy_out;
  logic        cfg_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          blk0[$];
  int          blk1[$];
  int          m_df;
  int          m_k;
  logic [1:0]  m_mode;
  logic        m_cfg;
  logic [15:0] m_last;

  multi_channel_decimator dut (
    .clk         (clk),
    .rst         (rst),
    .k           (k),
    .mode        (mode),
    .samples_in  (samples_in),
    .rdy_in      (rdy_in),
    .samples_out (samples_out),
    .rdy_out     (rdy_out),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reduce one completed block of a channel according to the block's mode.
  function automatic int reduce(input int q[$], input int kk, input logic [1:0] md);
    int  r;
    bit  avg;
`ifdef PEAK_DETECT_EN
    avg = (md == 2'b00);
`else
    avg = (md != 2'b01);
`endif
    if (avg) begin
      r = 0;
      foreach (q[i]) r += q[i];
      r = r / (1 << kk);
    end else begin
      r = q[0];
      foreach (q[i]) begin
        if (md == 2'b10 && q[i] > r) r = q[i];
        if (md == 2'b11 && q[i] < r) r = q[i];
      end
    end
    return r;
  endfunction

  function automatic void model_clear();
    blk0.delete();
    blk1.delete();
    m_cfg  = 1'b0;
    m_last = 16'h0000;
  endfunction

  // One clock cycle: optionally present a sample pair, then check outputs.
  task automatic step(input bit v, input int s0, input int s1);
    bit exp_rdy;
    int r0, r1;
    exp_rdy = 1'b0;
    @(negedge clk);
    rdy_in     = v;
    samples_in = {s1[7:0], s0[7:0]};
    @(posedge clk);
    #1;
    if (v) begin
      if (blk0.size() == 0) begin
        m_k = (k > 3'd4) ? 4 : int'(k);
        if (k > 3'd4) m_cfg = 1'b1;
        m_df   = 1 << m_k;
        m_mode = mode;
      end
      blk0.push_back(s0 & 255);
      blk1.push_back(s1 & 255);
      if (blk0.size() == m_df) begin
        r0 = reduce(blk0, m_k, m_mode);
        r1 = reduce(blk1, m_k, m_mode);
        m_last = {r1[7:0], r0[7:0]};
        blk0.delete();
        blk1.delete();
        exp_rdy = 1'b1;
      end
    end
    chk("rdy_out", {31'd0, rdy_out}, {31'd0, exp_rdy});
    chk("samples_out", {16'd0, samples_out}, {16'd0, m_last});
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_cfg});
    if (exp_rdy)
      $display("result ch0=%0d ch1=%0d k_eff=%0d mode=%0d", m_last[7:0], m_last[15:8], m_k, m_mode);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rdy_in = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_samples_out", {16'd0, samples_out}, 32'd0);
    chk("rst_rdy_out", {31'd0, rdy_out}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rdy_in     = 1'b0;
    k          = 3'd0;
    mode       = 2'b00;
    samples_in = 16'h0000;
    model_clear();
    #12;
    chk("init_samples_out", {16'd0, samples_out}, 32'd0);
    chk("init_rdy_out", {31'd0, rdy_out}, 32'd0);
    chk("init_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Average of 4: ch0 10,20,30,40 -> 25, ch1 255s -> 255
    k = 3'd2; mode = 2'b00;
    step(1, 10, 255);
    step(1, 20, 255);
    step(0, 0, 0);
    step(1, 30, 255);
    step(1, 40, 255);
    chk("avg4_const", {16'd0, samples_out}, 32'h0000FF19);
    step(0, 0, 0);

    // DF=1, back-to-back
    k = 3'd0;
    step(1, 7, 1);
    chk("df1_first", {24'd0, samples_out[7:0]}, 32'd7);
    step(1, 9, 2);
    chk("df1_second", {24'd0, samples_out[7:0]}, 32'd9);
    step(0, 0, 0);

    // Peak modes (average when peak detection is not built)
    k = 3'd2; mode = 2'b10;
    step(1, 5, 0); step(1, 200, 0); step(1, 3, 0); step(1, 90, 0);
`ifdef PEAK_DETECT_EN
    chk("max_const", {24'd0, samples_out[7:0]}, 32'd200);
`else
    chk("max_as_avg", {24'd0, samples_out[7:0]}, 32'd74);
`endif
    mode = 2'b11;
    step(1, 5, 0); step(1, 200, 0); step(1, 3, 0); step(1, 90, 0);
`ifdef PEAK_DETECT_EN
    chk("min_const", {24'd0, samples_out[7:0]}, 32'd3);
`else
    chk("min_as_avg", {24'd0, samples_out[7:0]}, 32'd74);
`endif

    // Decimate; k change mid-block only affects the next block
    k = 3'd2; mode = 2'b01;
    step(1, 11, 50); step(1, 12, 51);
    k = 3'd1;
    step(1, 13, 52); step(1, 14, 53);
    chk("dec_const", {24'd0, samples_out[7:0]}, 32'd11);
    step(1, 20, 60); step(1, 21, 61);
    chk("dec_k1", {24'd0, samples_out[7:0]}, 32'd20);

    // k beyond range: clamped to 16-sample blocks, sticky error
    k = 3'd7; mode = 2'b00;
    for (int i = 0; i < 16; i++) step(1, 255, 255);
    chk("clamp_const", {16'd0, samples_out}, 32'h0000FFFF);
    k = 3'd0;
    step(1, 1, 1);
    step(0, 0, 0);

    // Reset mid-block discards partial block
    k = 3'd2; mode = 2'b00;
    step(1, 100, 100); step(1, 100, 100);
    do_reset();
    step(1, 4, 4); step(1, 4, 4); step(1, 8, 8); step(1, 8, 8);
    chk("post_rst_avg", {24'd0, samples_out[7:0]}, 32'd6);
    step(0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        k    = 3'($urandom_range(0, 7));
        mode = 2'($urandom_range(0, 3));
      end
      if (i == 250) do_reset();
      step($urandom_range(0, 2) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_decimator.md
MULTI_CHANNEL_DECIMATOR -- requirements
Module: multi_channel_decimator

Interface
REQ-001 Parameter BITS_ADC, default 8, width of one channel sample.
REQ-002 Parameter BITS_ACUM, default 12, per-channel accumulator width; BIT_DIFF = BITS_ACUM-BITS_ADC.
REQ-003 Parameter NUM_CH, default 2, number of channels processed in lockstep.
REQ-004 clk  input  1  fpga clock; single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 k  input  $clog2(BIT_DIFF)+1  log2 of decimation factor DF.
REQ-007 mode  input  2  00 average, 01 decimate, 10 max, 11 min.
REQ-008 samples_in  input  NUM_CH*BITS_ADC  packed samples, channel 0 in LSBs.
REQ-009 rdy_in  input  1  samples_in valid this cycle.
REQ-010 samples_out  output  NUM_CH*BITS_ADC  packed result, channel 0 in LSBs.
REQ-011 rdy_out  output  1  one-cycle pulse, samples_out holds a new result.
REQ-012 cfg_err  output  1  sticky flag, k exceeded BIT_DIFF.

Function
REQ-013 Internal remaining-sample counter cnt (BIT_DIFF+1 bits); cnt==0 means next accepted sample starts a block.
REQ-014 On rdy_in with cnt==0: latch k_eff=min(k,BIT_DIFF) and mode into shadow registers, load acc[c]=sample[c] for all c, set cnt=DF-1 where DF=1<<k_eff.
REQ-015 k and mode changes while cnt!=0 are ignored until the next block start.
REQ-016 If k>BIT_DIFF at block start, k_eff=BIT_DIFF and cfg_err is set; cfg_err clears only on rst.
REQ-017 On rdy_in with cnt!=0: cnt decrements; acc[c] updates per mode: average acc+sample; decimate unchanged (first sample of block kept); max max(acc,sample); min min(acc,sample); comparisons unsigned.
REQ-018 Block completes on the rdy_in that makes cnt reach 0 (including DF=1, completing on the starting sample).
REQ-019 At completion, samples_out[c] = updated acc[c]>>k_eff for average, updated acc[c] for other modes; rdy_out high the following cycle (latency 1 clk from final rdy_in edge).
REQ-020 Average accumulator cannot overflow: DF*(2^BITS_ADC-1) fits BITS_ACUM bits by clamp in REQ-016.
REQ-021 samples_out holds its last value between results; rdy_out is high exactly one cycle per completed block.
REQ-022 Cycles without rdy_in change no state except rdy_out returning to 0.
REQ-023 Back-to-back rdy_in across a block boundary: completion and next block start occur on consecutive cycles with no lost sample.
REQ-024 All channels share cnt, k_eff and mode; channels never diverge in block alignment.

Reset
REQ-025 rst asynchronously clears cnt, acc, shadow k/mode, samples_out, rdy_out, cfg_err to 0.
REQ-026 rst mid-block discards the partial block; first rdy_in after release starts a new block.

Configuration
REQ-027 Macro PEAK_DETECT_EN: defined, modes 10/11 give max/min per REQ-017; undefined, comparators are not built and modes 10/11 behave as average (00).

Verification
REQ-028 NUM_CH=2, k=2, mode=00, channel 0 inputs 10,20,30,40 (ch1 all 255) -> one rdy_out pulse, ch0=25, ch1=255, one cycle after 4th rdy_in.
REQ-029 k=0, mode=00, rdy_in every cycle with ch0=7,9 -> rdy_out every cycle after first, samples_out ch0 7 then 9.
REQ-030 k=7 (BITS_ACUM=12) -> cfg_err=1, blocks of 16 samples; 16 inputs of 255 -> output 255, no overflow.
REQ-031 With PEAK_DETECT_EN, k=2, mode=10 then 11, inputs 5,200,3,90 -> outputs 200 then 3; without macro same stimulus -> 74 both.
REQ-032 k=2, mode=01, inputs 11,12,13,14 -> output 11; change k to 1 after 2nd sample -> block still 4 samples, next block 2 samples.
REQ-033 rst asserted after 2 of 4 samples -> outputs 0 immediately; next 4 samples 4,4,8,8 average -> 6, rdy_out exactly once.
